// File: rtl/te_instr_window.sv
// Trace encoder instruction window: holds next/current/previous records and
// classifies the current record once its successor is known.
module te_instr_window #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned INST_LEN  = 32,
  parameter int unsigned CAUSE_LEN = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_iretired_i,
  input  logic                 in_exception_i,
  input  logic                 in_interrupt_i,
  input  logic [CAUSE_LEN-1:0] in_cause_i,
  input  logic [XLEN-1:0]      in_tval_i,
  input  logic [INST_LEN-1:0]  in_inst_i,
  input  logic [XLEN-1:0]      in_pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      out_pc_o,
  output logic [CAUSE_LEN-1:0] out_cause_o,
  output logic [XLEN-1:0]      out_tval_o,
  output logic                 out_iretired_o,
  output logic                 out_exception_o,
  output logic                 out_interrupt_o,
  output logic                 out_compressed_o,
  output logic                 out_branch_o,
  output logic                 out_taken_o,
  output logic                 out_updiscon_o,
  output logic                 out_first_o,
  output logic                 out_next_trap_o
);

  typedef struct packed {
    logic                 iretired;
    logic                 exception;
    logic                 interrupt;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [INST_LEN-1:0]  inst;
    logic [XLEN-1:0]      pc;
  } rec_t;

  localparam logic [INST_LEN-1:0] InstMret = INST_LEN'(32'h3020_0073);
  localparam logic [INST_LEN-1:0] InstSret = INST_LEN'(32'h1020_0073);

  rec_t in_rec;
  rec_t nc_q, nc_d, cc_q, cc_d;
  logic nc_v_q, nc_v_d, cc_v_q, cc_v_d, pc_v_q, pc_v_d;
  logic pc_trap_q, pc_trap_d, emitted_q, emitted_d;
  logic full, out_valid, accept;

  assign in_rec = '{iretired:  in_iretired_i,
                    exception: in_exception_i,
                    interrupt: in_interrupt_i,
                    cause:     in_cause_i,
                    tval:      in_tval_i,
                    inst:      in_inst_i,
                    pc:        in_pc_i};

  assign full       = cc_v_q & nc_v_q;
  assign out_valid  = full & ~emitted_q;
  assign in_ready_o = ~out_valid | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;

  // Window shift / flush / emitted-flag next state
  always_comb begin
    nc_d      = nc_q;
    cc_d      = cc_q;
    nc_v_d    = nc_v_q;
    cc_v_d    = cc_v_q;
    pc_v_d    = pc_v_q;
    pc_trap_d = pc_trap_q;
    emitted_d = emitted_q;
    if (flush_i) begin
      nc_v_d    = 1'b0;
      cc_v_d    = 1'b0;
      pc_v_d    = 1'b0;
      emitted_d = 1'b0;
    end else if (accept) begin
      pc_v_d    = cc_v_q;
      pc_trap_d = cc_q.exception | cc_q.interrupt;
      cc_d      = nc_q;
      cc_v_d    = nc_v_q;
      nc_d      = in_rec;
      nc_v_d    = 1'b1;
      emitted_d = 1'b0;
    end else if (out_valid && out_ready_i) begin
      emitted_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nc_q      <= '0;
      cc_q      <= '0;
      nc_v_q    <= 1'b0;
      cc_v_q    <= 1'b0;
      pc_v_q    <= 1'b0;
      pc_trap_q <= 1'b0;
      emitted_q <= 1'b0;
    end else begin
      nc_q      <= nc_d;
      cc_q      <= cc_d;
      nc_v_q    <= nc_v_d;
      cc_v_q    <= cc_v_d;
      pc_v_q    <= pc_v_d;
      pc_trap_q <= pc_trap_d;
      emitted_q <= emitted_d;
    end
  end

  // Classification of the current record
  logic [INST_LEN-1:0] inst;
  logic                cc_trap, compressed, is_branch, is_jump;
  logic [XLEN-1:0]     cc_seq_pc;

  assign inst       = cc_q.inst;
  assign cc_trap    = cc_q.exception | cc_q.interrupt;
  assign compressed = inst[1:0] != 2'b11;
  assign cc_seq_pc  = cc_q.pc + (compressed ? XLEN'(2) : XLEN'(4));
  assign is_branch  = (inst[6:0] == 7'b1100011) ||
                      ((inst[1:0] == 2'b01) && (inst[15:14] == 2'b11));
  assign is_jump    = (inst[6:0] == 7'b1100111) ||
                      ((inst[1:0] == 2'b10) && (inst[15:13] == 3'b100) &&
                       (inst[11:7] != 5'd0) && (inst[6:2] == 5'd0)) ||
                      (inst == InstMret) || (inst == InstSret);

  // Everything reads zero unless the window holds both cc and nc
  assign out_valid_o      = out_valid;
  assign out_pc_o         = full ? cc_q.pc : '0;
  assign out_cause_o      = full ? cc_q.cause : '0;
  assign out_tval_o       = full ? cc_q.tval : '0;
  assign out_iretired_o   = full & cc_q.iretired;
  assign out_exception_o  = full & cc_q.exception;
  assign out_interrupt_o  = full & cc_q.interrupt;
  assign out_compressed_o = full & compressed;
  assign out_branch_o     = full & is_branch & ~cc_trap;
  assign out_taken_o      = full & is_branch & ~cc_trap & cc_q.iretired &
                            (nc_q.pc != cc_seq_pc);
  assign out_updiscon_o   = full & is_jump & ~cc_trap;
  assign out_first_o      = full & (~pc_v_q | pc_trap_q);
  assign out_next_trap_o  = full & (nc_q.exception | nc_q.interrupt);

endmodule

// File: tb/tb_te_instr_window.sv
// Directed testbench for te_instr_window.
module tb_te_instr_window;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        in_iretired_i, in_exception_i, in_interrupt_i;
  logic [4:0]  in_cause_i;
  logic [63:0] in_tval_i;
  logic [31:0] in_inst_i;
  logic [63:0] in_pc_i;
  logic        out_valid_o, out_ready_i;
  logic [63:0] out_pc_o;
  logic [4:0]  out_cause_o;
  logic [63:0] out_tval_o;
  logic        out_iretired_o, out_exception_o, out_interrupt_o;
  logic        out_compressed_o, out_branch_o, out_taken_o, out_updiscon_o;
  logic        out_first_o, out_next_trap_o;

  int n_checks = 0;
  int n_pass   = 0;

  te_instr_window #(.XLEN(64), .INST_LEN(32), .CAUSE_LEN(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_iretired_i(in_iretired_i), .in_exception_i(in_exception_i),
    .in_interrupt_i(in_interrupt_i), .in_cause_i(in_cause_i),
    .in_tval_i(in_tval_i), .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_cause_o(out_cause_o), .out_tval_o(out_tval_o),
    .out_iretired_o(out_iretired_o), .out_exception_o(out_exception_o),
    .out_interrupt_o(out_interrupt_o), .out_compressed_o(out_compressed_o),
    .out_branch_o(out_branch_o), .out_taken_o(out_taken_o),
    .out_updiscon_o(out_updiscon_o), .out_first_o(out_first_o),
    .out_next_trap_o(out_next_trap_o)
  );

  always #5 clk_i = ~clk_i;

  // Offer one record and wait (bounded) for it to be accepted
  task automatic push(input logic [63:0] pc, input logic [31:0] inst,
                      input logic exc = 1'b0, input logic [4:0] cause = 5'd0,
                      input logic [63:0] tval = 64'd0);
    int budget = 20;
    in_valid_i = 1'b1; in_pc_i = pc; in_inst_i = inst;
    in_exception_i = exc; in_interrupt_i = 1'b0; in_iretired_i = ~exc;
    in_cause_i = cause; in_tval_i = tval;
    while (!in_ready_o && budget > 0) begin
      @(posedge clk_i); #1;
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      $display("FAIL push_timeout pc=%h in_ready=%b want 1", pc, in_ready_o);
    end else begin
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic consume();
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic flush_win();
    flush_i = 1'b1; out_ready_i = 1'b0;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_iretired_i = 1'b0; in_exception_i = 1'b0; in_interrupt_i = 1'b0;
    in_cause_i = '0; in_tval_i = '0; in_inst_i = '0; in_pc_i = '0;
    #2;
    n_checks++;
    if ({in_ready_o, out_valid_o, out_pc_o, out_cause_o, out_tval_o,
         out_iretired_o, out_exception_o, out_interrupt_o, out_compressed_o,
         out_branch_o, out_taken_o, out_updiscon_o, out_first_o,
         out_next_trap_o} !== {1'b1, 1'b0, 64'd0, 5'd0, 64'd0, 9'd0})
      $display("FAIL reset_state ready=%b valid=%b pc=%h first=%b comp=%b want ready=1 rest 0",
               in_ready_o, out_valid_o, out_pc_o, out_first_o, out_compressed_o);
    else n_pass++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    flush_win();
    push(64'h1000, 32'h0000_0013);
    n_checks++;
    if (out_valid_o !== 1'b0)
      $display("FAIL basic_one_record valid=%b want 0", out_valid_o);
    else n_pass++;
    push(64'h1004, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_pc_o, out_first_o, out_compressed_o, out_branch_o,
         out_taken_o, out_updiscon_o, out_iretired_o, out_next_trap_o} !==
        {1'b1, 64'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL basic_out valid=%b pc=%h first=%b comp=%b br=%b want 1 1000 1 0 0",
               out_valid_o, out_pc_o, out_first_o, out_compressed_o, out_branch_o);
    else n_pass++;
    consume();
    n_checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01)
      $display("FAIL basic_emitted valid=%b ready=%b want 0 1", out_valid_o, in_ready_o);
    else n_pass++;
  endtask

  task automatic test_branch();
    flush_win();
    push(64'h2000, 32'h00b5_0463);
    push(64'h2008, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_pc_o, out_branch_o, out_taken_o, out_updiscon_o} !==
        {1'b1, 64'h2000, 1'b1, 1'b1, 1'b0})
      $display("FAIL branch_taken pc=%h br=%b tk=%b upd=%b want 2000 1 1 0",
               out_pc_o, out_branch_o, out_taken_o, out_updiscon_o);
    else n_pass++;
    consume();
    flush_win();
    push(64'h2000, 32'h00b5_0463);
    push(64'h2004, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_branch_o, out_taken_o} !== 3'b110)
      $display("FAIL branch_not_taken valid=%b br=%b tk=%b want 1 1 0",
               out_valid_o, out_branch_o, out_taken_o);
    else n_pass++;
    consume();
    // sequential successor wraps to address zero
    flush_win();
    push(64'hFFFF_FFFF_FFFF_FFFC, 32'h00b5_0463);
    push(64'h0, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_branch_o, out_taken_o} !== 3'b110)
      $display("FAIL branch_wrap valid=%b br=%b tk=%b want 1 1 0",
               out_valid_o, out_branch_o, out_taken_o);
    else n_pass++;
    consume();
  endtask

  task automatic test_compressed();
    flush_win();
    push(64'h3000, 32'h0000_8082);
    push(64'h5000, 32'h3020_0073);
    n_checks++;
    if ({out_valid_o, out_pc_o, out_compressed_o, out_updiscon_o, out_branch_o, out_first_o} !==
        {1'b1, 64'h3000, 1'b1, 1'b1, 1'b0, 1'b1})
      $display("FAIL c_jr pc=%h comp=%b upd=%b br=%b first=%b want 3000 1 1 0 1",
               out_pc_o, out_compressed_o, out_updiscon_o, out_branch_o, out_first_o);
    else n_pass++;
    consume();
    push(64'h6000, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_pc_o, out_compressed_o, out_updiscon_o, out_first_o} !==
        {1'b1, 64'h5000, 1'b0, 1'b1, 1'b0})
      $display("FAIL mret pc=%h comp=%b upd=%b first=%b want 5000 0 1 0",
               out_pc_o, out_compressed_o, out_updiscon_o, out_first_o);
    else n_pass++;
    consume();
  endtask

  task automatic test_backpressure();
    flush_win();
    push(64'h7000, 32'h0000_0013);
    push(64'h7004, 32'h0000_0013);
    in_valid_i = 1'b1; in_pc_i = 64'h7008; in_inst_i = 32'h0000_0013;
    in_exception_i = 1'b0; in_iretired_i = 1'b1;
    repeat (3) begin @(posedge clk_i); #1; end
    n_checks++;
    if ({in_ready_o, out_valid_o, out_pc_o, out_first_o} !== {1'b0, 1'b1, 64'h7000, 1'b1})
      $display("FAIL bp_stall ready=%b valid=%b pc=%h first=%b want 0 1 7000 1",
               in_ready_o, out_valid_o, out_pc_o, out_first_o);
    else n_pass++;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n_checks++;
    if ({out_valid_o, out_pc_o, out_first_o} !== {1'b1, 64'h7004, 1'b0})
      $display("FAIL bp_release valid=%b pc=%h first=%b want 1 7004 0",
               out_valid_o, out_pc_o, out_first_o);
    else n_pass++;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b0)
      $display("FAIL bp_no_dup valid=%b want 0", out_valid_o);
    else n_pass++;
    push(64'h700C, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_pc_o} !== {1'b1, 64'h7008})
      $display("FAIL bp_third valid=%b pc=%h want 1 7008", out_valid_o, out_pc_o);
    else n_pass++;
    consume();
  endtask

  task automatic test_trap();
    flush_win();
    push(64'h4000, 32'h0000_0013);
    push(64'h4004, 32'h00b5_0463, 1'b1, 5'd2, 64'hdead);
    n_checks++;
    if ({out_valid_o, out_pc_o, out_next_trap_o, out_first_o} !== {1'b1, 64'h4000, 1'b1, 1'b1})
      $display("FAIL trap_next pc=%h next_trap=%b first=%b want 4000 1 1",
               out_pc_o, out_next_trap_o, out_first_o);
    else n_pass++;
    consume();
    push(64'h8000, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_pc_o, out_exception_o, out_iretired_o, out_cause_o, out_tval_o} !==
        {1'b1, 64'h4004, 1'b1, 1'b0, 5'd2, 64'hdead})
      $display("FAIL trap_rec pc=%h exc=%b ret=%b cause=%0d tval=%h want 4004 1 0 2 dead",
               out_pc_o, out_exception_o, out_iretired_o, out_cause_o, out_tval_o);
    else n_pass++;
    n_checks++;
    if ({out_branch_o, out_taken_o, out_updiscon_o, out_next_trap_o, out_first_o} !== 5'b00000)
      $display("FAIL trap_forced br=%b tk=%b upd=%b nt=%b first=%b want 0 0 0 0 0",
               out_branch_o, out_taken_o, out_updiscon_o, out_next_trap_o, out_first_o);
    else n_pass++;
    consume();
    push(64'h8004, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_pc_o, out_first_o, out_next_trap_o} !== {1'b1, 64'h8000, 1'b1, 1'b0})
      $display("FAIL trap_after pc=%h first=%b nt=%b want 8000 1 0",
               out_pc_o, out_first_o, out_next_trap_o);
    else n_pass++;
    consume();
  endtask

  task automatic test_back_to_back();
    logic [63:0] pcs [4];
    logic [31:0] insts [4];
    logic [4:0]  exp_f [3];
    pcs[0] = 64'hA000; insts[0] = 32'h0000_0013;
    pcs[1] = 64'hA004; insts[1] = 32'h0000_E001;
    pcs[2] = 64'hA010; insts[2] = 32'h0000_80E7;
    pcs[3] = 64'hB000; insts[3] = 32'h0000_0013;
    // {compressed, branch, taken, updiscon, first}
    exp_f[0] = 5'b00001; exp_f[1] = 5'b11100; exp_f[2] = 5'b00010;
    flush_win();
    out_ready_i = 1'b1;
    in_exception_i = 1'b0; in_iretired_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in_valid_i = 1'b1; in_pc_i = pcs[i]; in_inst_i = insts[i];
      end else begin
        in_valid_i = 1'b0;
      end
      @(posedge clk_i); #1;
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if ({out_valid_o, out_pc_o, out_compressed_o, out_branch_o, out_taken_o,
             out_updiscon_o, out_first_o} !== {1'b1, pcs[i-1], exp_f[i-1]})
          $display("FAIL b2b_%0d valid=%b pc=%h flags=%b want pc=%h flags=%b", i, out_valid_o,
                   out_pc_o, {out_compressed_o, out_branch_o, out_taken_o, out_updiscon_o,
                   out_first_o}, pcs[i-1], exp_f[i-1]);
        else n_pass++;
      end else if (i == 4) begin
        n_checks++;
        if (out_valid_o !== 1'b0)
          $display("FAIL b2b_drain valid=%b want 0", out_valid_o);
        else n_pass++;
      end
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_flush_reset();
    flush_win();
    push(64'hC000, 32'h0000_0013);
    push(64'hC004, 32'h0000_0013);
    flush_i = 1'b1; out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_pc_i = 64'hDEAD0; in_inst_i = 32'h0000_0013;
    @(posedge clk_i); #1;
    flush_i = 1'b0; out_ready_i = 1'b0; in_valid_i = 1'b0;
    n_checks++;
    if ({out_valid_o, out_pc_o} !== {1'b0, 64'd0})
      $display("FAIL flush_clear valid=%b pc=%h want 0 0", out_valid_o, out_pc_o);
    else n_pass++;
    push(64'hC100, 32'h0000_0013);
    n_checks++;
    if (out_valid_o !== 1'b0)
      $display("FAIL flush_drop valid=%b pc=%h want 0", out_valid_o, out_pc_o);
    else n_pass++;
    push(64'hC104, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_pc_o, out_first_o} !== {1'b1, 64'hC100, 1'b1})
      $display("FAIL flush_restart pc=%h first=%b want C100 1", out_pc_o, out_first_o);
    else n_pass++;
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({out_valid_o, in_ready_o, out_pc_o, out_first_o} !== {1'b0, 1'b1, 64'd0, 1'b0})
      $display("FAIL reset_mid valid=%b ready=%b pc=%h first=%b want 0 1 0 0",
               out_valid_o, in_ready_o, out_pc_o, out_first_o);
    else n_pass++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    push(64'hD000, 32'h0000_0013);
    push(64'hD004, 32'h0000_0013);
    n_checks++;
    if ({out_valid_o, out_pc_o, out_first_o} !== {1'b1, 64'hD000, 1'b1})
      $display("FAIL reset_restart pc=%h first=%b want D000 1", out_pc_o, out_first_o);
    else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_compressed();
    test_backpressure();
    test_trap();
    test_back_to_back();
    test_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
